aes_shift_rows_pipe: RTL

//  Elastic, parametrised AES ShiftRows/InvShiftRows stage for the round datapath.

---
 rtl/aes_shift_rows_pipe.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/aes_shift_rows_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : aes_shift_rows_pipe
//  Purpose  : Elastic AES ShiftRows / InvShiftRows / bypass stage for the
//             round datapath. It processes LANES independent 128-bit states
//             per beat. Each beat's mode is picked at the input.
//             The transform is applied combinationally ahead of slot 0.
//             PIPE_STAGES register slots with valid/ready flow control follow
//             the transform and set the latency.
//  Ports    :
//    clk        in   rising-edge clock
//    rst_n      in   asynchronous active-low reset
//    in_valid   in   input beat present
//    in_ready   out  stage accepts a beat this cycle
//    in_mode    in   00 ShiftRows, 01 InvShiftRows, 10 bypass, 11 reserved
//    in_data    in   128*LANES, lane k at bits [128k+127:128k]
//    in_tag     in   TAG_W sideband, passed through unchanged
//    out_valid  out  output beat present
//    out_ready  in   downstream accepts the beat
//    out_data   out  transformed states
//    out_tag    out  tag of the beat on out_data
//    out_err    out  beat was accepted with the reserved mode
//    occupancy  out  number of valid slots held (0..PIPE_STAGES)
//  Revision : 1.0  initial release
// ============================================================================
module aes_shift_rows_pipe #(
  parameter int LANES       = 1,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic [128*LANES-1:0]   in_data,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [128*LANES-1:0]   out_data,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_err,
  output logic [2:0]             occupancy
);

  localparam int DW   = 128 * LANES;
  localparam int LAST = PIPE_STAGES - 1;

  localparam logic [1:0] MODE_FWD = 2'b00;
  localparam logic [1:0] MODE_INV = 2'b01;
  localparam logic [1:0] MODE_RSV = 2'b11;

  // Byte i of a state sits at bits [127-8i -: 8], with row r = i%4 and
  // column c = i/4. For forward, out[r][c] takes in[r][(c+r)%4]. For inverse,
  // it takes in[r][(c-r+4)%4]. The loops unroll into pure wiring.
  function automatic logic [127:0] shift_rows(input logic [127:0] s,
                                              input logic         inv);
    logic [127:0] r;
    int           src_c;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        src_c = inv ? ((c - row + 4) % 4) : ((c + row) % 4);
        r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*src_c) -: 8];
      end
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Per-lane transform, ahead of slot 0
  // --------------------------------------------------------------------------
  logic [DW-1:0] xf_data;

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      always_comb begin
        xf_data[128*k +: 128] = in_data[128*k +: 128];
        case (in_mode)
          MODE_FWD: xf_data[128*k +: 128] = shift_rows(in_data[128*k +: 128], 1'b0);
          MODE_INV: xf_data[128*k +: 128] = shift_rows(in_data[128*k +: 128], 1'b1);
          default:  xf_data[128*k +: 128] = in_data[128*k +: 128];
        endcase
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Elastic slot chain
  // --------------------------------------------------------------------------
  logic [PIPE_STAGES-1:0] slot_valid;
  logic [DW-1:0]          slot_data [PIPE_STAGES];
  logic [TAG_W-1:0]       slot_tag  [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] slot_err;

  // The beat offered to each slot comes from the transform for slot 0 and
  // from the previous slot for every other slot.
  logic [PIPE_STAGES-1:0] up_valid;
  logic [DW-1:0]          up_data [PIPE_STAGES];
  logic [TAG_W-1:0]       up_tag  [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] up_err;

  always_comb begin
    up_valid   = '0;
    up_err     = '0;
    up_valid[0] = in_valid;
    up_data[0]  = xf_data;
    up_tag[0]   = in_tag;
    up_err[0]   = (in_mode == MODE_RSV);
    for (int i = 1; i < PIPE_STAGES; i++) begin
      up_valid[i] = slot_valid[i-1];
      up_data[i]  = slot_data[i-1];
      up_tag[i]   = slot_tag[i-1];
      up_err[i]   = slot_err[i-1];
    end
  end

  // take[i] is set when slot i can load on this edge. The slot may be empty,
  // or the next slot may take its beat on the same edge. For the last slot,
  // the beat may leave through out_ready. The chain runs combinationally from
  // out_ready back to in_ready, so a full pipe still streams at one beat per
  // cycle.
  logic [PIPE_STAGES-1:0] take;
  logic                   chain;

  always_comb begin
    take  = '0;
    chain = out_ready;
    for (int i = LAST; i >= 0; i--) begin
      take[i] = !slot_valid[i] || chain;
      chain   = take[i];
    end
  end

  // Payload fields load only with a valid beat. An empty slot therefore keeps
  // its last contents, and the output holds after the pipe drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= '0;
      slot_err   <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) begin
        slot_data[i] <= '0;
        slot_tag[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        if (take[i]) begin
          slot_valid[i] <= up_valid[i];
          if (up_valid[i]) begin
            slot_data[i] <= up_data[i];
            slot_tag[i]  <= up_tag[i];
            slot_err[i]  <= up_err[i];
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Handshake outputs and occupancy
  // --------------------------------------------------------------------------
  logic accept;
  logic emit;

  assign in_ready  = take[0];
  assign out_valid = slot_valid[LAST];
  assign out_data  = slot_data[LAST];
  assign out_tag   = slot_tag[LAST];
  // The error flag is reported only with its own beat.
  assign out_err   = slot_valid[LAST] & slot_err[LAST];

  assign accept = in_valid && take[0];
  assign emit   = slot_valid[LAST] && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= 3'd0;
    end else begin
      case ({accept, emit})
        2'b10:   occupancy <= occupancy + 3'd1;
        2'b01:   occupancy <= occupancy - 3'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule
`default_nettype wire
